// File: rtl/lpc_pkg.sv
// Shared definitions for the LPC I/O target front end.
// Holds the FSM state encoding, the LAD nibble constants used on the bus
// and the default claimed I/O address.
package lpc_pkg;

  // FSM state encoding (legacy-compatible plain constants)
  typedef logic [2:0] lpc_state_t;

  localparam lpc_state_t ST_IDLE    = 3'd0;
  localparam lpc_state_t ST_CYCTYPE = 3'd1;
  localparam lpc_state_t ST_ADDR    = 3'd2;
  localparam lpc_state_t ST_WDATA   = 3'd3;
  localparam lpc_state_t ST_HTAR    = 3'd4;
  localparam lpc_state_t ST_SYNC    = 3'd5;
  localparam lpc_state_t ST_RDATA   = 3'd6;
  localparam lpc_state_t ST_PTAR    = 3'd7;

  // LAD nibble values
  localparam logic [3:0] LAD_START  = 4'b0000;
  localparam logic [3:0] CYC_IO_RD  = 4'b0000;
  localparam logic [3:0] CYC_IO_WR  = 4'b0010;
  localparam logic [3:0] SYNC_READY = 4'b0000;
  localparam logic [3:0] SYNC_SWAIT = 4'b0101;
  localparam logic [3:0] LAD_TAR    = 4'b1111;

  localparam logic [15:0] DEFAULT_BASE_ADDR = 16'h0080;

  // Masked address compare: only bits set in mask take part.
  function automatic logic addr_match(input logic [15:0] addr, input logic [15:0] base,
                                      input logic [15:0] mask);
    return (addr & mask) == (base & mask);
  endfunction

endpackage

// File: rtl/lpc_io_target.sv
// LPC bus I/O target front end.
// Decodes host I/O read/write cycles on LAD/LFRAME# and produces single-cycle
// register strobes for the I/O-mapped devices behind it.
//
// Ports:
//   lclk, lreset_n    LPC clock, async active-low reset (LRESET#)
//   lframe_n, lad_in  LFRAME# and sampled LAD from the pad
//   lad_out, lad_oe   LAD drive value and pad output enable
//   addr, din         captured cycle address and write data
//   dout              read data from the selected device
//   device_cs         address-matched pulse, coincident with a strobe
//   io_wren, io_rden  one-cycle write / read strobes
//   lpc_en            high while a claimed cycle is in progress
module lpc_io_target
  import lpc_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR = DEFAULT_BASE_ADDR,
  parameter logic [15:0] ADDR_MASK = 16'hFFFF,
  parameter int unsigned SYNC_WAIT = 0
) (
  input  logic        lclk,
  input  logic        lreset_n,
  input  logic        lframe_n,
  input  logic [3:0]  lad_in,
  output logic [3:0]  lad_out,
  output logic        lad_oe,
  output logic [15:0] addr,
  output logic [7:0]  din,
  input  logic [7:0]  dout,
  output logic        device_cs,
  output logic        io_wren,
  output logic        io_rden,
  output logic        lpc_en
);

  localparam logic [3:0] SyncWaitW = 4'(SYNC_WAIT);

  lpc_state_t  state_q, state_d;
  logic [1:0]  nib_q, nib_d;
  logic [3:0]  wait_q, wait_d;
  logic        is_wr_q, is_wr_d;
  logic [15:0] addr_q, addr_d;
  logic [7:0]  din_q, din_d;
  logic [7:0]  dout_q, dout_d;
  logic        sync_ready;

  assign sync_ready = (state_q == ST_SYNC) && (wait_q == SyncWaitW);

  always_comb begin
    state_d = state_q;
    nib_d   = nib_q;
    wait_d  = wait_q;
    is_wr_d = is_wr_q;
    addr_d  = addr_q;
    din_d   = din_q;
    dout_d  = dout_q;

    if (sync_ready) begin
      dout_d = dout;
    end

    if (!lframe_n) begin
      // START or host abort: takes priority in every state and suppresses capture
      state_d = (lad_in == LAD_START) ? ST_CYCTYPE : ST_IDLE;
      nib_d   = 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_CYCTYPE: begin
          nib_d = 2'd0;
          if (lad_in == CYC_IO_RD) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else if (lad_in == CYC_IO_WR) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[11:0], lad_in};
          if (nib_q == 2'd3) begin
            nib_d = 2'd0;
            if (addr_match(addr_d, BASE_ADDR, ADDR_MASK)) begin
              state_d = is_wr_q ? ST_WDATA : ST_HTAR;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end
        ST_WDATA: begin
          // Data arrives least significant nibble first
          if (nib_q == 2'd0) begin
            din_d[3:0] = lad_in;
            nib_d      = 2'd1;
          end else begin
            din_d[7:4] = lad_in;
            nib_d      = 2'd0;
            state_d    = ST_HTAR;
          end
        end
        ST_HTAR: begin
          if (nib_q == 2'd1) begin
            nib_d   = 2'd0;
            wait_d  = 4'd0;
            state_d = ST_SYNC;
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end
        ST_SYNC: begin
          if (sync_ready) begin
            nib_d   = 2'd0;
            state_d = is_wr_q ? ST_PTAR : ST_RDATA;
          end else begin
            wait_d = wait_q + 4'd1;
          end
        end
        ST_RDATA: begin
          if (nib_q == 2'd1) begin
            nib_d   = 2'd0;
            state_d = ST_PTAR;
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end
        ST_PTAR: begin
          if (nib_q == 2'd1) begin
            nib_d   = 2'd0;
            state_d = ST_IDLE;
          end else begin
            nib_d = nib_q + 2'd1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge lclk or negedge lreset_n) begin
    if (!lreset_n) begin
      state_q <= ST_IDLE;
      nib_q   <= 2'd0;
      wait_q  <= 4'd0;
      is_wr_q <= 1'b0;
      addr_q  <= 16'h0000;
      din_q   <= 8'h00;
      dout_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      nib_q   <= nib_d;
      wait_q  <= wait_d;
      is_wr_q <= is_wr_d;
      addr_q  <= addr_d;
      din_q   <= din_d;
      dout_q  <= dout_d;
    end
  end

  // LAD drive is decoded from registered state only; no path from lad_in.
  always_comb begin
    lad_oe  = 1'b0;
    lad_out = LAD_TAR;
    case (state_q)
      ST_SYNC: begin
        lad_oe  = 1'b1;
        lad_out = sync_ready ? SYNC_READY : SYNC_SWAIT;
      end
      ST_RDATA: begin
        lad_oe  = 1'b1;
        lad_out = (nib_q == 2'd0) ? dout_q[3:0] : dout_q[7:4];
      end
      ST_PTAR: begin
        lad_oe  = (nib_q == 2'd0);
        lad_out = LAD_TAR;
      end
      default: ;
    endcase
  end

  assign device_cs = sync_ready;
  assign io_wren   = sync_ready & is_wr_q;
  assign io_rden   = sync_ready & ~is_wr_q;
  // States past a successful address match
  assign lpc_en    = (state_q == ST_WDATA) || (state_q == ST_HTAR) || (state_q == ST_SYNC) ||
                     (state_q == ST_RDATA) || (state_q == ST_PTAR);
  assign addr      = addr_q;
  assign din       = din_q;

endmodule

// File: tb/tb_lpc_io_target.sv
module tb_lpc_io_target;

  localparam int NI = 3;
  localparam logic [15:0] BASE = 16'h0080;

  logic       lclk;
  logic       lreset_n;
  logic       lframe_n;
  logic [3:0] lad_in;
  logic [7:0] dout;

  logic [3:0]  lad_out_w [NI];
  logic        lad_oe_w  [NI];
  logic [15:0] addr_w    [NI];
  logic [7:0]  din_w     [NI];
  logic        cs_w      [NI];
  logic        wren_w    [NI];
  logic        rden_w    [NI];
  logic        en_w      [NI];

  int          inst_wait [NI] = '{0, 3, 0};
  logic [15:0] inst_mask [NI] = '{16'hFFFF, 16'hFFFF, 16'hFFF0};

  logic [15:0] exp_addr;
  logic [7:0]  exp_din [NI];

  int checks;
  int failures;

  typedef struct packed {
    logic       oe;
    logic [3:0] out;
    logic       cs;
    logic       wr;
    logic       rd;
    logic       en;
  } exp_t;

  lpc_io_target #(.SYNC_WAIT(0)) u_dut0 (
    .lclk(lclk), .lreset_n(lreset_n), .lframe_n(lframe_n), .lad_in(lad_in),
    .lad_out(lad_out_w[0]), .lad_oe(lad_oe_w[0]), .addr(addr_w[0]), .din(din_w[0]),
    .dout(dout), .device_cs(cs_w[0]), .io_wren(wren_w[0]), .io_rden(rden_w[0]),
    .lpc_en(en_w[0])
  );

  lpc_io_target #(.SYNC_WAIT(3)) u_dut3 (
    .lclk(lclk), .lreset_n(lreset_n), .lframe_n(lframe_n), .lad_in(lad_in),
    .lad_out(lad_out_w[1]), .lad_oe(lad_oe_w[1]), .addr(addr_w[1]), .din(din_w[1]),
    .dout(dout), .device_cs(cs_w[1]), .io_wren(wren_w[1]), .io_rden(rden_w[1]),
    .lpc_en(en_w[1])
  );

  lpc_io_target #(.ADDR_MASK(16'hFFF0)) u_dutm (
    .lclk(lclk), .lreset_n(lreset_n), .lframe_n(lframe_n), .lad_in(lad_in),
    .lad_out(lad_out_w[2]), .lad_oe(lad_oe_w[2]), .addr(addr_w[2]), .din(din_w[2]),
    .dout(dout), .device_cs(cs_w[2]), .io_wren(wren_w[2]), .io_rden(rden_w[2]),
    .lpc_en(en_w[2])
  );

  initial lclk = 1'b0;
  always #5 lclk = ~lclk;

  // Expected target behaviour in cycle k after START (T0), derived from the cycle timeline.
  function automatic exp_t model(bit claimed, bit wr, int w, int k, int abort_at,
                                 logic [7:0] rdata);
    exp_t e;
    int   sync_s, ready, last;
    e = '0;
    e.out = 4'hF;
    if (!claimed) return e;
    if (abort_at > 0 && k > abort_at) return e;
    sync_s = wr ? 10 : 8;
    ready  = sync_s + w;
    last   = ready + (wr ? 2 : 4);
    if (k >= 6 && k <= last) e.en = 1'b1;
    if (k >= sync_s && k < ready) begin
      e.oe = 1'b1; e.out = 4'b0101;
    end else if (k == ready) begin
      e.oe = 1'b1; e.out = 4'b0000; e.cs = 1'b1; e.wr = wr; e.rd = !wr;
    end else if (!wr && k == ready + 1) begin
      e.oe = 1'b1; e.out = rdata[3:0];
    end else if (!wr && k == ready + 2) begin
      e.oe = 1'b1; e.out = rdata[7:4];
    end else if (k == last - 1) begin
      e.oe = 1'b1; e.out = 4'hF;
    end
    return e;
  endfunction

  task automatic run_txn(input logic [3:0] cyc, input logic [15:0] a, input logic [7:0] d,
                         input int abort_at, input int nk, input bit fix_rd,
                         input logic [7:0] rd_val, input string tag);
    logic [7:0] dseq [32];
    bit   valid, wr;
    bit   claimed [NI];
    exp_t e, act;
    int   ready;
    valid = (cyc == 4'b0000) || (cyc == 4'b0010);
    wr    = (cyc == 4'b0010);
    for (int k = 0; k < 32; k++) dseq[k] = fix_rd ? rd_val : 8'($urandom);
    for (int i = 0; i < NI; i++)
      claimed[i] = valid && ((a & inst_mask[i]) == (BASE & inst_mask[i])) &&
                   (abort_at == 0 || abort_at > 5);
    for (int k = 0; k < nk; k++) begin
      lframe_n = !(k == 0 || k == abort_at);
      dout     = dseq[k];
      if (k == 0) lad_in = 4'b0000;
      else if (k == abort_at) lad_in = 4'hF;
      else if (k == 1) lad_in = cyc;
      else if (k >= 2 && k <= 5) lad_in = a[15 - 4*(k-2) -: 4];
      else if (wr && k == 6) lad_in = d[3:0];
      else if (wr && k == 7) lad_in = d[7:4];
      else lad_in = 4'($urandom);
      if (k >= 1) begin
        for (int i = 0; i < NI; i++) begin
          ready = (wr ? 10 : 8) + inst_wait[i];
          e = model(claimed[i], wr, inst_wait[i], k, abort_at, dseq[ready]);
          act.oe  = lad_oe_w[i];
          act.out = lad_oe_w[i] ? lad_out_w[i] : 4'hF;
          act.cs  = cs_w[i];
          act.wr  = wren_w[i];
          act.rd  = rden_w[i];
          act.en  = en_w[i];
          checks++;
          if (act !== e) begin
            failures++;
            $display("FAIL %s inst%0d T%0d: got oe=%b lad=%h cs=%b wren=%b rden=%b en=%b, want oe=%b lad=%h cs=%b wren=%b rden=%b en=%b",
                     tag, i, k, act.oe, act.out, act.cs, act.wr, act.rd, act.en,
                     e.oe, e.out, e.cs, e.wr, e.rd, e.en);
          end
        end
      end
      @(posedge lclk);
      #1;
    end
    lframe_n = 1'b1;
    if (valid && (abort_at == 0 || abort_at > 5)) exp_addr = a;
    for (int i = 0; i < NI; i++) begin
      if (claimed[i] && wr) begin
        if (abort_at == 0 || abort_at > 6) exp_din[i][3:0] = d[3:0];
        if (abort_at == 0 || abort_at > 7) exp_din[i][7:4] = d[7:4];
      end
      checks++;
      if (addr_w[i] !== exp_addr || din_w[i] !== exp_din[i]) begin
        failures++;
        $display("FAIL %s_regs inst%0d: got addr=%h din=%h, want addr=%h din=%h",
                 tag, i, addr_w[i], din_w[i], exp_addr, exp_din[i]);
      end
    end
  endtask

  task automatic idle_cycles(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      lframe_n = 1'b1;
      lad_in   = 4'($urandom);
      for (int i = 0; i < NI; i++) begin
        checks++;
        if ({lad_oe_w[i], cs_w[i], wren_w[i], rden_w[i], en_w[i]} !== 5'b0) begin
          failures++;
          $display("FAIL %s inst%0d: got oe/cs/wren/rden/en=%b%b%b%b%b, want 00000", tag, i,
                   lad_oe_w[i], cs_w[i], wren_w[i], rden_w[i], en_w[i]);
        end
      end
      @(posedge lclk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int i = 0; i < NI; i++) begin
      checks++;
      if (lad_out_w[i] !== 4'hF || lad_oe_w[i] !== 1'b0 || addr_w[i] !== 16'h0 ||
          din_w[i] !== 8'h0 || cs_w[i] !== 1'b0 || wren_w[i] !== 1'b0 ||
          rden_w[i] !== 1'b0 || en_w[i] !== 1'b0) begin
        failures++;
        $display("FAIL %s inst%0d: got lad=%h oe=%b addr=%h din=%h cs=%b wren=%b rden=%b en=%b, want lad=f oe=0 addr=0000 din=00 cs=0 wren=0 rden=0 en=0",
                 tag, i, lad_out_w[i], lad_oe_w[i], addr_w[i], din_w[i], cs_w[i],
                 wren_w[i], rden_w[i], en_w[i]);
      end
    end
  endtask

  task automatic test_reset();
    lreset_n = 1'b0;
    lframe_n = 1'b1;
    lad_in   = 4'hF;
    dout     = 8'h00;
    exp_addr = 16'h0;
    for (int i = 0; i < NI; i++) exp_din[i] = 8'h0;
    #1;
    check_reset_vals("reset");
    repeat (2) @(posedge lclk);
    #1;
    lreset_n = 1'b1;
    idle_cycles(2, "post_reset_idle");
  endtask

  task automatic test_io_write();
    run_txn(4'b0010, 16'h0080, 8'h5A, 0, 18, 1'b0, 8'h00, "write_0080");
    idle_cycles(1, "write_idle");
  endtask

  task automatic test_io_read();
    run_txn(4'b0000, 16'h0080, 8'h00, 0, 18, 1'b1, 8'hC3, "read_0080");
    run_txn(4'b0000, 16'h0080, 8'h00, 0, 18, 1'b0, 8'h00, "read_rand");
  endtask

  task automatic test_addr_miss();
    run_txn(4'b0010, 16'h0084, 8'hA7, 0, 18, 1'b0, 8'h00, "write_0084");
    run_txn(4'b0000, 16'h1080, 8'h00, 0, 18, 1'b0, 8'h00, "read_1080");
  endtask

  task automatic test_bad_cyctype();
    run_txn(4'b0100, 16'h0080, 8'h11, 0, 14, 1'b0, 8'h00, "memrd");
    run_txn(4'b0010, 16'h0080, 8'h3C, 0, 16, 1'b0, 8'h00, "write_after_memrd");
  endtask

  task automatic test_abort_back_to_back();
    run_txn(4'b0010, 16'h0080, 8'hE1, 7, 8, 1'b0, 8'h00, "abort_wdata");
    run_txn(4'b0010, 16'h0080, 8'h96, 0, 16, 1'b0, 8'h00, "b2b_write");
  endtask

  task automatic test_long_start();
    lframe_n = 1'b0;
    lad_in   = 4'b0000;
    @(posedge lclk);
    #1;
    run_txn(4'b0000, 16'h0081, 8'h00, 0, 18, 1'b0, 8'h00, "long_start_read");
  endtask

  task automatic test_reset_mid();
    run_txn(4'b0000, 16'h0080, 8'h00, 0, 10, 1'b0, 8'h00, "pre_reset_read");
    checks++;
    if (lad_oe_w[1] !== 1'b1 || lad_out_w[1] !== 4'b0101) begin
      failures++;
      $display("FAIL reset_mid_wait: got oe=%b lad=%h, want oe=1 lad=5", lad_oe_w[1],
               lad_out_w[1]);
    end
    lreset_n = 1'b0;
    #1;
    exp_addr = 16'h0;
    for (int i = 0; i < NI; i++) exp_din[i] = 8'h0;
    check_reset_vals("reset_mid");
    @(posedge lclk);
    #1;
    lreset_n = 1'b1;
    run_txn(4'b0010, 16'h008F, 8'h42, 0, 18, 1'b0, 8'h00, "write_after_reset");
  endtask

  task automatic test_random();
    logic [15:0] addrs [5];
    logic [3:0]  cycs [4];
    logic [3:0]  cyc;
    int          ab;
    addrs = '{16'h0080, 16'h0084, 16'h008F, 16'h1080, 16'h0000};
    cycs  = '{4'b0000, 4'b0010, 4'b0100, 4'b0010};
    for (int n = 0; n < 12; n++) begin
      addrs[4] = 16'($urandom);
      cyc = cycs[$urandom_range(0, 3)];
      ab  = ($urandom_range(0, 3) == 0) ? 7 : 0;
      run_txn(cyc, addrs[$urandom_range(0, 4)], 8'($urandom), ab, 18, 1'b0, 8'h00, "random");
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_io_write();
    test_io_read();
    test_addr_miss();
    test_bad_cyctype();
    test_abort_back_to_back();
    test_long_start();
    test_reset_mid();
    test_random();
    idle_cycles(2, "final_idle");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
